// File: rtl/par2ser_stream.sv
// par2ser_stream: parallel-to-serial converter with valid/ready on both sides.
// A DATA_W-bit frame is emitted as DATA_W/LANE_W beats of LANE_W bits each.
// A one-frame holding buffer lets consecutive frames follow each other with
// no idle cycle between them. A saturating idle counter flags a missing input.
module par2ser_stream #(
    parameter int DATA_W    = 400,
    parameter int LANE_W    = 1,
    parameter bit LSB_FIRST = 1'b1,
    parameter int IDLE_MAX  = 480,
    parameter int IDLE_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [LANE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last,
    output logic              busy,
    output logic [IDLE_W-1:0] idle_cnt,
    output logic              idle_flag
);

    localparam int BEATS = DATA_W / LANE_W;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(IDLE_MAX + 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_shifted;
    logic [DATA_W-1:0] hold_buf;
    logic              hold_full;
    logic [CNT_W-1:0]  beat_cnt;
    logic [LANE_W-1:0] lane;
    logic [IDLE_W-1:0] idle_inc;
    logic              accept;
    logic              beat_xfer;
    logic              last_xfer;

    // in_ready comes straight from a flop, so in_valid never reaches it combinationally.
    assign in_ready  = ~hold_full;
    assign accept    = in_valid & in_ready;
    assign beat_xfer = out_valid & out_ready;
    assign last_xfer = beat_xfer & (beat_cnt == LAST_BEAT);

    // The outgoing lane always sits at the end of the shift register nearest the output.
    assign lane          = LSB_FIRST ? shreg[LANE_W-1:0] : shreg[DATA_W-1 -: LANE_W];
    assign shreg_shifted = LSB_FIRST ? (shreg >> LANE_W) : (shreg << LANE_W);
    assign idle_inc      = idle_cnt + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: every clocked assignment uses <= so all flops update from pre-edge values.
            state <= state_nxt;
        end
    end

    // Next-state logic: leave SHIFT only when the last beat goes out with nothing queued behind it.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_SHIFT;
            S_SHIFT: if (last_xfer && !hold_full && !accept) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: everything visible downstream is qualified by out_valid.
    always_comb begin
        out_valid = (state == S_SHIFT);
        out_first = out_valid & (beat_cnt == '0);
        out_last  = out_valid & (beat_cnt == LAST_BEAT);
        out_data  = out_valid ? lane : '0;
        busy      = out_valid | hold_full;
    end

    // Datapath: load, shift, holding-buffer fill and hand-off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the wide data registers are reset too, so a frame cut off by reset leaves no residue.
            shreg     <= '0;
            hold_buf  <= '0;
            hold_full <= 1'b0;
            beat_cnt  <= '0;
        end else if (state == S_IDLE) begin
            if (accept) begin
                shreg    <= in_data;
                beat_cnt <= '0;
            end
        end else if (last_xfer) begin
            beat_cnt <= '0;
            if (hold_full) begin
                shreg     <= hold_buf;
                hold_full <= 1'b0;
            end else if (accept) begin
                shreg <= in_data;
            end else begin
                shreg <= '0;
            end
        end else begin
            if (beat_xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
                shreg    <= shreg_shifted;
            end
            if (accept) begin
                hold_buf  <= in_data;
                hold_full <= 1'b1;
            end
        end
    end

    // Idle counter: cleared by an accepted frame, otherwise counts up and saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt  <= '0;
            idle_flag <= 1'b0;
        end else if (accept) begin
            idle_cnt  <= '0;
            idle_flag <= 1'b0;
        end else if (idle_cnt != IDLE_SAT) begin
            idle_cnt  <= idle_inc;
            idle_flag <= (idle_inc == IDLE_SAT);
        end
    end

endmodule
